oagu_tile_sched: RTL and testbench

OAGU_TILE_SCHED -- requirements
Module: oagu_tile_sched

---
 rtl/oagu_tile_sched_pkg.sv | 32 +++
 rtl/oagu_tile_sched_if.sv | 46 ++++
 rtl/oagu_desc_fifo.sv | 55 +++++
 rtl/oagu_tile_sched.sv | 143 ++++++++++++++
 tb/tb_oagu_tile_sched.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/oagu_tile_sched_pkg.sv
// Shared types for the output-address-generator tile scheduler:
// FSM encoding, descriptor layout and default watchdog limit.
package oagu_tile_sched_pkg;

  localparam int          DIM_W           = 8;
  localparam int          ADDR_W          = 13;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [DIM_W-1:0]  x_len;
    logic [DIM_W-1:0]  y_len;
    logic [DIM_W-1:0]  piece;
    logic [DIM_W-1:0]  store_len;
    logic [DIM_W-1:0]  jump_len;
    logic [ADDR_W-1:0] addr_start;
    logic              last;
  } desc_t;

  // A tile with any empty loop dimension cannot be computed.
  function automatic logic has_zero_dim(desc_t d);
    return (d.x_len == '0) || (d.y_len == '0) || (d.piece == '0);
  endfunction

endpackage

// File: rtl/oagu_tile_sched_if.sv
// Descriptor, control and status bundle between decoder/address generator
// (master side) and the tile scheduler (slave side).
interface oagu_tile_sched_if;

  logic                                    desc_valid;
  logic                                    desc_ready;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   desc_x_len;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   desc_y_len;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   desc_piece;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   desc_store_len;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   desc_jump_len;
  logic [oagu_tile_sched_pkg::ADDR_W-1:0]  desc_addr_start;
  logic                                    desc_last;
  logic                                    sched_clr;
  logic                                    calculate_end;
  logic                                    start_calculate;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   out_x_length;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   out_y_length;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   out_piece;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   store_length;
  logic [oagu_tile_sched_pkg::DIM_W-1:0]   jump_length;
  logic [oagu_tile_sched_pkg::ADDR_W-1:0]  addr_start_s;
  logic [1:0]                              buffer_flag;
  logic [15:0]                             tile_count;
  logic                                    busy;
  logic                                    layer_done;
  logic                                    err_zero;
  logic                                    err_timeout;

  modport master (
    output desc_valid, desc_x_len, desc_y_len, desc_piece, desc_store_len,
           desc_jump_len, desc_addr_start, desc_last, sched_clr, calculate_end,
    input  desc_ready, start_calculate, out_x_length, out_y_length, out_piece,
           store_length, jump_length, addr_start_s, buffer_flag, tile_count,
           busy, layer_done, err_zero, err_timeout
  );

  modport slave (
    input  desc_valid, desc_x_len, desc_y_len, desc_piece, desc_store_len,
           desc_jump_len, desc_addr_start, desc_last, sched_clr, calculate_end,
    output desc_ready, start_calculate, out_x_length, out_y_length, out_piece,
           store_length, jump_length, addr_start_s, buffer_flag, tile_count,
           busy, layer_done, err_zero, err_timeout
  );

endinterface

// File: rtl/oagu_desc_fifo.sv
// Synchronous descriptor FIFO; DEPTH must be a power of two so the
// extra pointer bit distinguishes full from empty.
module oagu_desc_fifo
  import oagu_tile_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  push_i,
  input  desc_t din_i,
  input  logic  pop_i,
  output desc_t dout_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  desc_t         mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/oagu_tile_sched.sv
// Tile scheduler: queues tile descriptors, hands each one to the output
// address generator and tracks completion, ping-pong buffer and errors.
module oagu_tile_sched
  import oagu_tile_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [15:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  oagu_tile_sched_if.slave  bus
);

  state_e      state_q, state_d;
  desc_t       cfg_q;
  desc_t       push_desc, head_desc;
  logic [15:0] wd_q, wd_d;
  logic [15:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        full, empty, push, pop;
  logic        start_pls, zero_pls, tmo_pls, layer_pls, done_act;

  assign push_desc = '{x_len:      bus.desc_x_len,
                       y_len:      bus.desc_y_len,
                       piece:      bus.desc_piece,
                       store_len:  bus.desc_store_len,
                       jump_len:   bus.desc_jump_len,
                       addr_start: bus.desc_addr_start,
                       last:       bus.desc_last};
  assign push = bus.desc_valid && !full && !bus.sched_clr;

  oagu_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.sched_clr),
    .push_i  (push),
    .din_i   (push_desc),
    .pop_i   (pop),
    .dout_o  (head_desc),
    .full_o  (full),
    .empty_o (empty)
  );

  // Completion wins over the watchdog when both land in the same RUN cycle.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    start_pls = 1'b0;
    zero_pls  = 1'b0;
    tmo_pls   = 1'b0;
    layer_pls = 1'b0;
    done_act  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (has_zero_dim(cfg_q)) begin
          zero_pls = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        start_pls = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (bus.calculate_end) begin
          state_d = ST_DONE;
        end else if (wd_q == TIMEOUT - 16'd1) begin
          tmo_pls = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        done_act  = 1'b1;
        layer_pls = cfg_q.last;
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.sched_clr) begin
      state_d   = ST_IDLE;
      pop       = 1'b0;
      start_pls = 1'b0;
      zero_pls  = 1'b0;
      tmo_pls   = 1'b0;
      layer_pls = 1'b0;
      done_act  = 1'b0;
    end

    wd_d    = (state_q == ST_RUN) ? wd_q + 16'd1 : 16'd0;
    count_d = done_act ? count_q + 16'd1 : count_q;
    flag_d  = done_act ? !flag_q : flag_q;
    if (bus.sched_clr) begin
      count_d = 16'd0;
      flag_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      wd_q    <= 16'd0;
      count_q <= 16'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      if (pop) cfg_q <= head_desc;
    end
  end

  assign bus.desc_ready      = !full;
  assign bus.start_calculate = start_pls;
  assign bus.err_zero        = zero_pls;
  assign bus.err_timeout     = tmo_pls;
  assign bus.layer_done      = layer_pls;
  assign bus.out_x_length    = cfg_q.x_len;
  assign bus.out_y_length    = cfg_q.y_len;
  assign bus.out_piece       = cfg_q.piece;
  assign bus.store_length    = cfg_q.store_len;
  assign bus.jump_length     = cfg_q.jump_len;
  assign bus.addr_start_s    = cfg_q.addr_start;
  assign bus.buffer_flag     = {1'b0, flag_q};
  assign bus.tile_count      = count_q;
  assign bus.busy            = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_oagu_tile_sched.sv
// Directed bench for oagu_tile_sched: a vector table of single tiles plus
// hand-written sequences for queueing, clear, reset and watchdog behaviour.
module tb_oagu_tile_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   startCount;
  int   layerCount;

  oagu_tile_sched_if bus ();
  oagu_tile_sched_if bus2 ();

  oagu_tile_sched #(.FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  oagu_tile_sched #(.FIFO_DEPTH(2), .TIMEOUT(16'd16)) dutTmo (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  p;
    logic [7:0]  st;
    logic [7:0]  jp;
    logic [12:0] addr;
    logic        last;
    int          delay;
    logic        expErrZero;
    logic [15:0] expCount;
    logic [1:0]  expFlag;
    logic        expLayer;
  } vec_t;

  vec_t vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.start_calculate) startCount++;
    if (bus.layer_done) layerCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Offers one descriptor for a single edge; caller is #1 after a posedge.
  task automatic applyStimulus(input vec_t v);
    bus.desc_valid      = 1'b1;
    bus.desc_x_len      = v.x;
    bus.desc_y_len      = v.y;
    bus.desc_piece      = v.p;
    bus.desc_store_len  = v.st;
    bus.desc_jump_len   = v.jp;
    bus.desc_addr_start = v.addr;
    bus.desc_last       = v.last;
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int startsBefore;
    int layersBefore;
    vec_t d;

    checks     = 0;
    errors     = 0;
    startCount = 0;
    layerCount = 0;

    vecs[0] = '{x:8'd4, y:8'd2, p:8'd3, st:8'd5, jp:8'd6, addr:13'h0100, last:1'b0,
                delay:24, expErrZero:1'b0, expCount:16'd1, expFlag:2'd1, expLayer:1'b0};
    vecs[1] = '{x:8'd1, y:8'd1, p:8'd0, st:8'd2, jp:8'd2, addr:13'h0055, last:1'b0,
                delay:0, expErrZero:1'b1, expCount:16'd1, expFlag:2'd1, expLayer:1'b0};
    vecs[2] = '{x:8'd2, y:8'd3, p:8'd1, st:8'd9, jp:8'd1, addr:13'h1FFF, last:1'b1,
                delay:3, expErrZero:1'b0, expCount:16'd2, expFlag:2'd0, expLayer:1'b1};
    vecs[3] = '{x:8'd0, y:8'd5, p:8'd5, st:8'd0, jp:8'd0, addr:13'h00AA, last:1'b0,
                delay:0, expErrZero:1'b1, expCount:16'd2, expFlag:2'd0, expLayer:1'b0};
    vecs[4] = '{x:8'd8, y:8'd1, p:8'd1, st:8'd8, jp:8'd0, addr:13'h0000, last:1'b0,
                delay:1, expErrZero:1'b0, expCount:16'd3, expFlag:2'd1, expLayer:1'b0};

    rst = 1'b1;
    bus.desc_valid = 1'b0;  bus.desc_x_len = '0;  bus.desc_y_len = '0;
    bus.desc_piece = '0;    bus.desc_store_len = '0;  bus.desc_jump_len = '0;
    bus.desc_addr_start = '0;  bus.desc_last = 1'b0;
    bus.sched_clr = 1'b0;   bus.calculate_end = 1'b0;
    bus2.desc_valid = 1'b0; bus2.desc_x_len = '0; bus2.desc_y_len = '0;
    bus2.desc_piece = '0;   bus2.desc_store_len = '0; bus2.desc_jump_len = '0;
    bus2.desc_addr_start = '0; bus2.desc_last = 1'b0;
    bus2.sched_clr = 1'b0;  bus2.calculate_end = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", bus.desc_ready, 1);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstCount", bus.tile_count, 0);
    checkOutput("rstFlag", bus.buffer_flag, 0);
    checkOutput("rstStart", bus.start_calculate, 0);
    checkOutput("rstX", bus.out_x_length, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      startsBefore = startCount;
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d errZero", i), bus.err_zero, vecs[i].expErrZero);
      checkOutput($sformatf("v%0d addr", i), bus.addr_start_s, vecs[i].addr);
      tick();
      checkOutput($sformatf("v%0d start", i), bus.start_calculate, !vecs[i].expErrZero);
      if (!vecs[i].expErrZero) begin
        repeat (vecs[i].delay) @(posedge clk);
        #1;
        bus.calculate_end = 1'b1;
        tick();
        bus.calculate_end = 1'b0;
        checkOutput($sformatf("v%0d layer", i), bus.layer_done, vecs[i].expLayer);
      end
      tick();
      checkOutput($sformatf("v%0d count", i), bus.tile_count, vecs[i].expCount);
      checkOutput($sformatf("v%0d flag", i), bus.buffer_flag, vecs[i].expFlag);
      checkOutput($sformatf("v%0d nStarts", i), startCount - startsBefore, !vecs[i].expErrZero);
      checkOutput($sformatf("v%0d cfgX", i), bus.out_x_length, vecs[i].x);
      checkOutput($sformatf("v%0d cfgStore", i), bus.store_length, vecs[i].st);
    end

    // Reset mid-RUN, then a fresh descriptor with normal latency.
    d = vecs[0];
    applyStimulus(d);
    repeat (3) tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midRstReady", bus.desc_ready, 1);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstAddr", bus.addr_start_s, 0);
    checkOutput("midRstPiece", bus.out_piece, 0);
    checkOutput("midRstCount", bus.tile_count, 0);
    checkOutput("midRstFlag", bus.buffer_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    startsBefore = startCount;
    repeat (3) tick();
    checkOutput("postRstNoStart", startCount - startsBefore, 0);
    d.addr = 13'h0ABC;
    applyStimulus(d);
    checkOutput("lat1", bus.start_calculate, 0);
    tick();
    checkOutput("lat2", bus.start_calculate, 0);
    tick();
    checkOutput("lat3", bus.start_calculate, 1);
    checkOutput("latAddr", bus.addr_start_s, 13'h0ABC);
    tick();
    bus.calculate_end = 1'b1;
    tick();
    bus.calculate_end = 1'b0;
    tick();
    checkOutput("latCount", bus.tile_count, 1);

    bus.sched_clr = 1'b1;
    tick();
    bus.sched_clr = 1'b0;
    checkOutput("clrCount", bus.tile_count, 0);
    checkOutput("clrFlag", bus.buffer_flag, 0);

    // Three back-to-back tiles, last one closes the layer.
    layersBefore = layerCount;
    d = vecs[4];
    applyStimulus(d);
    applyStimulus(d);
    d.last = 1'b1;
    applyStimulus(d);
    checkOutput("b2bReadyLow", bus.desc_ready, 0);
    for (int t = 0; t < 3; t++) begin
      checkOutput($sformatf("b2b%0d start", t), bus.start_calculate, 1);
      checkOutput($sformatf("b2b%0d flagBefore", t), bus.buffer_flag, t % 2);
      tick();
      bus.calculate_end = 1'b1;
      tick();
      bus.calculate_end = 1'b0;
      checkOutput($sformatf("b2b%0d layer", t), bus.layer_done, (t == 2));
      tick();
      checkOutput($sformatf("b2b%0d flagAfter", t), bus.buffer_flag, (t + 1) % 2);
      checkOutput($sformatf("b2b%0d count", t), bus.tile_count, t + 1);
      if (t < 2) begin
        checkOutput($sformatf("b2b%0d loadNoStart", t), bus.start_calculate, 0);
        tick();
      end
    end
    checkOutput("b2bLayers", layerCount - layersBefore, 1);

    // calculate_end in IDLE and START is ignored; clear abandons RUN.
    bus.calculate_end = 1'b1;
    repeat (2) tick();
    bus.calculate_end = 1'b0;
    checkOutput("idleEndCount", bus.tile_count, 3);
    layersBefore = layerCount;
    d.last = 1'b1;
    applyStimulus(d);
    applyStimulus(d);
    applyStimulus(d);
    checkOutput("clrSeqStart", bus.start_calculate, 1);
    bus.calculate_end = 1'b1;
    tick();
    bus.calculate_end = 1'b0;
    tick();
    checkOutput("startEndIgnored", bus.busy, 1);
    checkOutput("startEndCount", bus.tile_count, 3);
    checkOutput("queuedFull", bus.desc_ready, 0);
    startsBefore = startCount;
    bus.sched_clr = 1'b1;
    tick();
    bus.sched_clr = 1'b0;
    checkOutput("clrBusy", bus.busy, 0);
    checkOutput("clrReady", bus.desc_ready, 1);
    checkOutput("clrRunCount", bus.tile_count, 0);
    checkOutput("clrRunFlag", bus.buffer_flag, 0);
    repeat (4) tick();
    checkOutput("clrNoStart", startCount - startsBefore, 0);
    checkOutput("clrNoLayer", layerCount - layersBefore, 0);

    // Watchdog on the TIMEOUT=16 instance.
    bus2.desc_x_len = 8'd1;
    bus2.desc_y_len = 8'd1;
    bus2.desc_piece = 8'd1;
    bus2.desc_valid = 1'b1;
    tick();
    bus2.desc_valid = 1'b0;
    tick();
    tick();
    checkOutput("tmoStart", bus2.start_calculate, 1);
    tick();
    for (int k = 1; k < 16; k++) begin
      checkOutput($sformatf("tmoEarly%0d", k), bus2.err_timeout, 0);
      tick();
    end
    checkOutput("tmoPulse", bus2.err_timeout, 1);
    tick();
    checkOutput("tmoPulseEnd", bus2.err_timeout, 0);
    checkOutput("tmoBusy", bus2.busy, 0);
    checkOutput("tmoCount", bus2.tile_count, 0);
    checkOutput("tmoFlag", bus2.buffer_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
